// File: rtl/if_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package if_pkg;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_inst_fifo.sv
// Synchronous instruction buffer holding {pc, inst} entries.
// Flush empties it in one cycle; pointers wrap modulo DEPTH.
module if_inst_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction fetch stage with multiple outstanding requests and a PC-tagged buffer.
// Optional IF_PREFETCH_BYPASS_EN: zero-latency path from response to IR when the buffer is empty.
module if_prefetch_unit
    import if_pkg::*;
#(
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] PC,
    output logic        Inst_Req_Valid,
    input  logic        Inst_Req_Ready,
    input  logic [31:0] Instruction,
    input  logic        Inst_Valid,
    output logic        Inst_Ready,
    output logic [31:0] IR,
    output logic [31:0] IR_PC,
    output logic        Done_O,
    input  logic        Next_Ready,
    input  logic [31:0] next_PC,
    input  logic        Feedback_Branch,
    input  logic        Feedback_Mem_Acc
);

    localparam int            OW      = $clog2(MAX_OUTSTANDING + 1);
    localparam int            CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

    logic          running;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] outstanding_nxt;
    logic [OW-1:0] discard;
    logic [OW-1:0] discard_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   target_pc;
    logic [31:0]   reserved;
    logic [CW-1:0] fifo_count;
    logic          req_fire;
    logic          resp_fire;
    logic          resp_dec;
    logic          keep;
    logic          push;
    logic          pop;
    fetch_entry_t  head;
    fetch_entry_t  resp_entry;

    assign target_pc = next_PC & ~32'h3;

    // Buffered entries plus responses still owed to us; stale responses are not counted.
    assign reserved = 32'(fifo_count) + 32'(outstanding) - 32'(discard);

    assign Inst_Ready     = running;
    assign PC             = fetch_pc;
    assign Inst_Req_Valid = running && !Feedback_Branch && !Feedback_Mem_Acc
                            && (outstanding < MAX_OUT) && (reserved < 32'(FIFO_DEPTH));

    assign req_fire   = Inst_Req_Valid && Inst_Req_Ready;
    assign resp_fire  = Inst_Valid && Inst_Ready;
    assign resp_dec   = resp_fire && (outstanding != '0);
    assign keep       = resp_fire && !Feedback_Branch && (discard == '0);
    assign resp_entry = '{pc: resp_pc, inst: Instruction};
    assign pop        = (fifo_count != '0) && Next_Ready && !Feedback_Branch;

`ifdef IF_PREFETCH_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit = keep && (fifo_count == '0);
    assign push       = keep && !(bypass_hit && Next_Ready);
    assign Done_O     = (fifo_count != '0) || bypass_hit;
    assign IR         = bypass_hit ? Instruction : head.inst;
    assign IR_PC      = bypass_hit ? resp_pc : head.pc;
`else
    assign push   = keep;
    assign Done_O = (fifo_count != '0);
    assign IR     = head.inst;
    assign IR_PC  = head.pc;
`endif

    always_comb begin
        outstanding_nxt = outstanding;
        if (req_fire && !resp_dec) begin
            outstanding_nxt = outstanding + OW'(1);
        end else if (!req_fire && resp_dec) begin
            outstanding_nxt = outstanding - OW'(1);
        end

        discard_nxt = discard;
        if (Feedback_Branch) begin
            discard_nxt = outstanding_nxt;
        end else if (resp_fire && (discard != '0)) begin
            discard_nxt = discard - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running     <= 1'b0;
            outstanding <= '0;
            discard     <= '0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
        end else begin
            running     <= 1'b1;
            outstanding <= outstanding_nxt;
            discard     <= discard_nxt;
            if (Feedback_Branch) begin
                fetch_pc <= target_pc;
                resp_pc  <= target_pc;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (keep) begin
                    resp_pc <= resp_pc + PC_STEP;
                end
            end
        end
    end

    if_inst_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (Feedback_Branch),
        .push      (push),
        .push_data (resp_entry),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: epoch-tagged memory/pipeline model, directed corner cases,
// a wrap/alignment vector table and a randomized run.
module tb_if_prefetch_unit;

    localparam int          DEPTH   = 4;
    localparam int          MAX_OUT = 2;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ready;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ready;
    logic [31:0] IR;
    logic [31:0] IR_PC;
    logic        Done_O;
    logic        Next_Ready;
    logic [31:0] next_PC;
    logic        Feedback_Branch;
    logic        Feedback_Mem_Acc;

    if_prefetch_unit #(
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAX_OUT),
        .RESET_PC        (RST_PC)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .PC               (PC),
        .Inst_Req_Valid   (Inst_Req_Valid),
        .Inst_Req_Ready   (Inst_Req_Ready),
        .Instruction      (Instruction),
        .Inst_Valid       (Inst_Valid),
        .Inst_Ready       (Inst_Ready),
        .IR               (IR),
        .IR_PC            (IR_PC),
        .Done_O           (Done_O),
        .Next_Ready       (Next_Ready),
        .next_PC          (next_PC),
        .Feedback_Branch  (Feedback_Branch),
        .Feedback_Mem_Acc (Feedback_Mem_Acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mem_req_t;

    typedef struct {
        logic [31:0] target;
        logic [31:0] exp_pc;
        logic [31:0] exp_next;
    } wrap_vec_t;

    mem_req_t    mem_q[$];
    logic [63:0] exp_q[$];
    int          cur_epoch;
    int          cyc;
    logic [31:0] model_pc;
    bit          running;
    bit          last_req_fire;
    int          passed;
    int          total;

    bit          drv_branch;
    bit          drv_mem_acc;
    bit          drv_next_ready;
    bit          drv_req_ready;
    logic [31:0] drv_target;
    int          lat_min;
    int          lat_max;

    function automatic logic [31:0] inst_of(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check1(string name, logic act, logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_timeout(string name);
        total++;
        $display("FAIL %s: wait bound expired, got no event expected event (cycle %0d)", name, cyc);
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic step();
        bit       resp;
        bit       exp_valid;
        bit       req_fire;
        int       live;
        mem_req_t r;
        @(negedge clk);
        Feedback_Branch  = drv_branch;
        next_PC          = drv_target;
        Feedback_Mem_Acc = drv_mem_acc;
        Next_Ready       = drv_next_ready;
        Inst_Req_Ready   = drv_req_ready;
        resp             = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        Inst_Valid       = resp;
        Instruction      = resp ? inst_of(mem_q[0].addr) : $urandom;
        #1;
        live = 0;
        foreach (mem_q[i]) if (mem_q[i].epoch == cur_epoch) live++;
        exp_valid = running && !drv_branch && !drv_mem_acc && (mem_q.size() < MAX_OUT)
                    && ((exp_q.size() + live) < DEPTH);
        check1("req_valid", Inst_Req_Valid, exp_valid);
        check32("pc", PC, model_pc);
        check1("inst_ready", Inst_Ready, running);
        check1("done", Done_O, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            check32("ir", IR, exp_q[0][31:0]);
            check32("ir_pc", IR_PC, exp_q[0][63:32]);
        end

        req_fire      = exp_valid && drv_req_ready;
        last_req_fire = req_fire;
        if (resp) r = mem_q.pop_front();
        if (drv_branch) begin
            exp_q.delete();
            cur_epoch++;
            model_pc = drv_target & ~32'h3;
        end else begin
            if ((exp_q.size() > 0) && drv_next_ready) void'(exp_q.pop_front());
            if (resp && (r.epoch == cur_epoch)) exp_q.push_back({r.addr, inst_of(r.addr)});
        end
        if (req_fire) begin
            mem_q.push_back('{addr: model_pc, epoch: cur_epoch, due: cyc + $urandom_range(lat_max, lat_min)});
            model_pc = model_pc + 32'd4;
        end
        cyc++;
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_drv(bit req_ready, bit next_ready, bit mem_acc, int lmin, int lmax);
        drv_req_ready  = req_ready;
        drv_next_ready = next_ready;
        drv_mem_acc    = mem_acc;
        drv_branch     = 1'b0;
        lat_min        = lmin;
        lat_max        = lmax;
    endtask

    task automatic apply_reset();
        rst_n            = 1'b0;
        running          = 1'b0;
        Inst_Valid       = 1'b0;
        Instruction      = 32'h0;
        Feedback_Branch  = 1'b0;
        Feedback_Mem_Acc = 1'b0;
        Next_Ready       = 1'b0;
        Inst_Req_Ready   = 1'b0;
        next_PC          = 32'h0;
        set_drv(1'b1, 1'b1, 1'b0, 1, 1);
        drv_target = 32'h0;
        mem_q.delete();
        exp_q.delete();
        model_pc = RST_PC;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check1("rst_req_valid", Inst_Req_Valid, 1'b0);
        check32("rst_pc", PC, RST_PC);
        check1("rst_inst_ready", Inst_Ready, 1'b0);
        check1("rst_done", Done_O, 1'b0);
        check32("rst_ir", IR, 32'h0);
        check32("rst_ir_pc", IR_PC, 32'h0);
        rst_n   = 1'b1;
        running = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wrap_vec_t vecs[4];
        int        k;
        bit        seen;
        vecs[0] = '{target: 32'h0000_0103, exp_pc: 32'h0000_0100, exp_next: 32'h0000_0104};
        vecs[1] = '{target: 32'hFFFF_FFFC, exp_pc: 32'hFFFF_FFFC, exp_next: 32'h0000_0000};
        vecs[2] = '{target: 32'h0000_0007, exp_pc: 32'h0000_0004, exp_next: 32'h0000_0008};
        vecs[3] = '{target: 32'h2000_0001, exp_pc: 32'h2000_0000, exp_next: 32'h2000_0004};

        passed    = 0;
        total     = 0;
        cyc       = 0;
        cur_epoch = 0;

        // Sequential fetch with a 1-cycle memory.
        apply_reset();
        step();
        check1("first_valid_after_reset", Inst_Req_Valid, 1'b1);
        steps(20);

        // Stalled decoder: buffer fills, requests stop, then resume.
        apply_reset();
        set_drv(1'b1, 1'b0, 1'b0, 1, 1);
        steps(12);
        check1("full_req_valid", Inst_Req_Valid, 1'b0);
        check1("full_done", Done_O, 1'b1);
        drv_next_ready = 1'b1;
        steps(12);

        // Two outstanding at 0x8/0xC, branch to 0x100.
        apply_reset();
        set_drv(1'b1, 1'b1, 1'b0, 1, 1);
        k = 0;
        while (model_pc != 32'h8 && k < 20) begin step(); k++; end
        if (model_pc != 32'h8) fail_timeout("reach_pc8");
        drv_req_ready = 1'b0;
        steps(3);
        drv_req_ready = 1'b1;
        lat_min = 6;
        lat_max = 6;
        k = 0;
        while (mem_q.size() < 2 && k < 20) begin step(); k++; end
        if (mem_q.size() < 2) fail_timeout("two_outstanding");
        drv_branch = 1'b1;
        drv_target = 32'h0000_0100;
        step();
        drv_branch = 1'b0;
        lat_min = 1;
        lat_max = 1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step();
            if (Done_O) begin
                seen = 1'b1;
                check32("branch_first_ir_pc", IR_PC, 32'h0000_0100);
            end
        end
        if (!seen) fail_timeout("branch_first_ir");

        // Branch coinciding with a response and a pop.
        apply_reset();
        set_drv(1'b1, 1'b1, 1'b0, 1, 1);
        steps(6);
        drv_branch = 1'b1;
        drv_target = 32'h0000_0040;
        step();
        drv_branch = 1'b0;
        step();
        check1("branch_resp_done", Done_O, 1'b0);
        check32("branch_resp_pc", PC, 32'h0000_0040);
        steps(6);

        // Shared memory busy for 5 cycles while the buffer drains.
        apply_reset();
        set_drv(1'b1, 1'b0, 1'b0, 1, 1);
        steps(8);
        drv_next_ready = 1'b1;
        drv_mem_acc    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check1("mem_acc_blocks", Inst_Req_Valid, 1'b0);
        end
        drv_mem_acc = 1'b0;
        step();
        check1("mem_acc_release_valid", Inst_Req_Valid, 1'b1);
        steps(4);

        // Redirect alignment and address wrap.
        apply_reset();
        for (int v = 0; v < 4; v++) begin
            set_drv(1'b1, 1'b1, 1'b0, 1, 1);
            drv_branch = 1'b1;
            drv_target = vecs[v].target;
            step();
            drv_branch = 1'b0;
            step();
            check32("vec_target_pc", PC, vecs[v].exp_pc);
            k = 0;
            while (!last_req_fire && k < 30) begin step(); k++; end
            if (!last_req_fire) fail_timeout("vec_handshake");
            step();
            check32("vec_next_pc", PC, vecs[v].exp_next);
            steps(3);
        end

        // Randomized traffic.
        apply_reset();
        set_drv(1'b1, 1'b1, 1'b0, 1, 3);
        for (int n = 0; n < 3000; n++) begin
            drv_req_ready  = ($urandom_range(3, 0) != 0);
            drv_next_ready = ($urandom_range(3, 0) != 0);
            drv_mem_acc    = ($urandom_range(9, 0) == 0);
            drv_branch     = !drv_branch && ($urandom_range(24, 0) == 0);
            drv_target     = $urandom;
            step();
        end
        set_drv(1'b1, 1'b1, 1'b0, 1, 1);
        steps(20);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
